// File: rtl/img2col_rf_ctrl_if.sv
// Pixel-stream, register-file and window handshake bundle for img2col_rf_ctrl.
// The controller takes the master side; the pixel source / MAC array take the slave side.
interface img2col_rf_ctrl_if #(
    parameter int data_width  = 16,
    parameter int address_num = 5,
    parameter int cnt_width   = 16
);
    logic                   flush;
    logic                   px_valid;
    logic                   px_ready;
    logic [data_width-1:0]  px_data1;
    logic [data_width-1:0]  px_data2;
    logic                   rf_wr_ctrl;
    logic                   rf_r_ctrl;
    logic [data_width-1:0]  rf_in1;
    logic [data_width-1:0]  rf_in2;
    logic [address_num-1:0] rf_adrs_in1;
    logic [address_num-1:0] rf_adrs_in2;
    logic                   win_valid;
    logic                   win_ready;
    logic [cnt_width-1:0]   win_count;
    logic                   busy;

    modport master (
        input  flush, px_valid, px_data1, px_data2, win_ready,
        output px_ready, rf_wr_ctrl, rf_r_ctrl, rf_in1, rf_in2,
               rf_adrs_in1, rf_adrs_in2, win_valid, win_count, busy
    );

    modport slave (
        output flush, px_valid, px_data1, px_data2, win_ready,
        input  px_ready, rf_wr_ctrl, rf_r_ctrl, rf_in1, rf_in2,
               rf_adrs_in1, rf_adrs_in2, win_valid, win_count, busy
    );
endinterface

// File: rtl/img2col_rf_ctrl.sv
// Write/read sequencer for the two-write-port img2col register file: loads a window
// two pixels per beat, bulk-reads it, and hands it downstream while the next one loads.
module img2col_rf_ctrl #(
    parameter int data_width  = 16,
    parameter int reg_num     = 25,
    parameter int address_num = 5,
    parameter int cnt_width   = 16
) (
    input logic                clk,
    input logic                rst,
    img2col_rf_ctrl_if.master  bus
);
    localparam int unsigned            NB        = (reg_num + 1) / 2;
    localparam bit                     ODD       = (reg_num % 2) == 1;
    localparam logic [address_num-1:0] LAST_BEAT = address_num'(NB - 1);

    typedef enum logic [1:0] {
        ST_FILL,
        ST_WAIT,
        ST_CAPTURE
    } state_e;

    state_e                 state_q, state_d;
    logic [address_num-1:0] beat_q, beat_d;
    logic                   win_valid_q, win_valid_d;
    logic [cnt_width-1:0]   win_count_q, win_count_d;
    logic                   busy_q, busy_d;

    logic                   px_ready;
    logic                   wr_ctrl;
    logic                   r_ctrl;
    logic [data_width-1:0]  in1, in2;
    logic [address_num-1:0] adrs1, adrs2;
    logic                   slot_free;
    logic                   last_beat;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        win_valid_d = win_valid_q;
        win_count_d = win_count_q;
        px_ready    = 1'b0;
        wr_ctrl     = 1'b0;
        r_ctrl      = 1'b0;
        in1         = '0;
        in2         = '0;
        adrs1       = '0;
        adrs2       = '0;
        slot_free   = !win_valid_q || bus.win_ready;
        last_beat   = (beat_q == LAST_BEAT);

        if (bus.win_ready) win_valid_d = 1'b0;

        if (!rst) begin
            unique case (state_q)
                ST_FILL: begin
                    px_ready = !bus.flush;
                    if (bus.flush) begin
                        beat_d = '0;
                    end else if (bus.px_valid) begin
                        wr_ctrl = 1'b1;
                        adrs1   = address_num'({beat_q, 1'b0});
                        adrs2   = address_num'({beat_q, 1'b1});
                        in1     = bus.px_data1;
                        in2     = bus.px_data2;
                        // Odd window: last beat writes px_data1 twice so no address past reg_num-1 is issued.
                        if (ODD && last_beat) begin
                            adrs2 = adrs1;
                            in2   = bus.px_data1;
                        end
                        if (last_beat) begin
                            beat_d  = '0;
                            state_d = slot_free ? ST_CAPTURE : ST_WAIT;
                        end else begin
                            beat_d = beat_q + address_num'(1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.flush) begin
                        beat_d  = '0;
                        state_d = ST_FILL;
                    end else if (slot_free) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    r_ctrl      = 1'b1;
                    win_valid_d = 1'b1;
                    win_count_d = win_count_q + cnt_width'(1);
                    state_d     = ST_FILL;
                end
                default: state_d = ST_FILL;
            endcase
        end

        busy_d = (state_d != ST_FILL) || (beat_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            beat_q      <= '0;
            win_valid_q <= 1'b0;
            win_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            win_valid_q <= win_valid_d;
            win_count_q <= win_count_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.px_ready    = px_ready;
    assign bus.rf_wr_ctrl  = wr_ctrl;
    assign bus.rf_r_ctrl   = r_ctrl;
    assign bus.rf_in1      = in1;
    assign bus.rf_in2      = in2;
    assign bus.rf_adrs_in1 = adrs1;
    assign bus.rf_adrs_in2 = adrs2;
    assign bus.win_valid   = win_valid_q;
    assign bus.win_count   = win_count_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_img2col_rf_ctrl.sv
// Scoreboard bench for img2col_rf_ctrl: directed scenarios plus a randomized stream,
// with a second small (reg_num=4) instance checked against a fixed cycle table.
module tb_img2col_rf_ctrl;
    localparam int DW = 16;
    localparam int RN = 25;
    localparam int AN = 5;
    localparam int CW = 16;
    localparam int NB = (RN + 1) / 2;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    img2col_rf_ctrl_if #(.data_width(DW), .address_num(AN), .cnt_width(CW)) bus ();
    img2col_rf_ctrl_if #(.data_width(DW), .address_num(2), .cnt_width(CW)) bus2 ();

    img2col_rf_ctrl #(.data_width(DW), .reg_num(RN), .address_num(AN), .cnt_width(CW)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    img2col_rf_ctrl #(.data_width(DW), .reg_num(4), .address_num(2), .cnt_width(CW)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the k-th accepted pair of a window lands at 2k / 2k+1.
    typedef struct {
        logic [AN-1:0] a1;
        logic [AN-1:0] a2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
    } wr_t;

    wr_t        wq[$];
    int         cq[$];
    int         k_model   = 0;
    int         cnt_model = 0;

    function automatic void model_beat(input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        wr_t w;
        w.a1 = AN'(2 * k_model);
        w.d1 = d1;
        if ((RN % 2 == 1) && (k_model == NB - 1)) begin
            w.a2 = AN'(2 * k_model);
            w.d2 = d1;
        end else begin
            w.a2 = AN'(2 * k_model + 1);
            w.d2 = d2;
        end
        wq.push_back(w);
        k_model++;
        if (k_model == NB) begin
            k_model = 0;
            cq.push_back(cnt_model);
            cnt_model++;
        end
    endfunction

    task automatic send_pair(input logic [DW-1:0] d1, input logic [DW-1:0] d2);
        int budget = 200;
        bit done   = 1'b0;
        bus.px_valid = 1'b1;
        bus.px_data1 = d1;
        bus.px_data2 = d2;
        while (!done) begin
            @(negedge clk);
            if (bus.px_ready) begin
                model_beat(d1, d2);
                done = 1'b1;
            end else begin
                budget--;
                if (budget == 0) begin
                    chk("px_ready_timeout", 64'd0, 64'd1);
                    done = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        bus.px_valid = 1'b0;
        bus.px_data1 = '0;
        bus.px_data2 = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Monitor: pops expected writes/captures whenever the DUT strobes.
    logic          cap_pending = 1'b0;
    logic [CW-1:0] cap_exp;
    wr_t           mw;
    int            me;

    always begin
        @(negedge clk); #1;
        chk("strobe_excl", 64'(bus.rf_wr_ctrl && bus.rf_r_ctrl), 64'd0);
        if (bus.rf_wr_ctrl) begin
            if (wq.size() == 0) begin
                chk("unexpected_write", 64'd1, 64'd0);
            end else begin
                mw = wq.pop_front();
                chk("wr_adrs1", 64'(bus.rf_adrs_in1), 64'(mw.a1));
                chk("wr_adrs2", 64'(bus.rf_adrs_in2), 64'(mw.a2));
                chk("wr_in1", 64'(bus.rf_in1), 64'(mw.d1));
                chk("wr_in2", 64'(bus.rf_in2), 64'(mw.d2));
            end
        end else begin
            chk("rf_idle_zero",
                64'({bus.rf_adrs_in1, bus.rf_adrs_in2, bus.rf_in1, bus.rf_in2}), 64'd0);
        end
        if (cap_pending) begin
            chk("win_valid_after_capture", 64'(bus.win_valid), 64'd1);
            chk("win_count_after_capture", 64'(bus.win_count), 64'(cap_exp + CW'(1)));
            cap_pending = 1'b0;
        end
        if (bus.rf_r_ctrl) begin
            if (cq.size() == 0) begin
                chk("unexpected_capture", 64'd1, 64'd0);
            end else begin
                me = cq.pop_front();
                cap_exp = CW'(me);
                chk("win_count_at_capture", 64'(bus.win_count), 64'(cap_exp));
                chk("win_valid_at_capture", 64'(bus.win_valid), 64'd0);
                cap_pending = 1'b1;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    bit drv_done;
    int exp_wr[6] = '{1, 1, 0, 1, 1, 0};
    int exp_r[6]  = '{0, 0, 1, 0, 0, 1};
    int exp_a1[6] = '{0, 2, 0, 0, 2, 0};
    int exp_a2[6] = '{1, 3, 0, 1, 3, 0};

    initial begin
        rst = 1'b1;
        rst2 = 1'b1;
        bus.flush = 1'b0;
        bus.px_valid = 1'b1;
        bus.px_data1 = 16'h1234;
        bus.px_data2 = 16'h5678;
        bus.win_ready = 1'b0;
        bus2.flush = 1'b0;
        bus2.px_valid = 1'b0;
        bus2.px_data1 = '0;
        bus2.px_data2 = '0;
        bus2.win_ready = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_px_ready", 64'(bus.px_ready), 64'd0);
        chk("rst_wr_ctrl", 64'(bus.rf_wr_ctrl), 64'd0);
        tick();
        rst = 1'b0;
        rst2 = 1'b0;
        bus.px_valid = 1'b0;
        bus.px_data1 = '0;
        bus.px_data2 = '0;
        @(negedge clk);
        chk("reset_win_valid", 64'(bus.win_valid), 64'd0);
        chk("reset_win_count", 64'(bus.win_count), 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        tick();

        // Back-to-back window: capture in the cycle after the 13th beat.
        for (int k = 0; k < NB; k++) send_pair(DW'(2 * k), DW'(2 * k + 1));
        @(negedge clk);
        chk("s1_capture_strobe", 64'(bus.rf_r_ctrl), 64'd1);
        chk("s1_capture_px_ready", 64'(bus.px_ready), 64'd0);
        chk("s1_capture_busy", 64'(bus.busy), 64'd1);
        tick();
        @(negedge clk);
        chk("s1_win_valid", 64'(bus.win_valid), 64'd1);
        chk("s1_win_count", 64'(bus.win_count), 64'd1);
        chk("s1_busy_idle", 64'(bus.busy), 64'd0);
        chk("s1_px_ready", 64'(bus.px_ready), 64'd1);
        tick();

        // Second window loads while the first is held; then sits waiting.
        for (int k = 0; k < NB; k++) send_pair(DW'(100 + 2 * k), DW'(101 + 2 * k));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("s2_wait_px_ready", 64'(bus.px_ready), 64'd0);
            chk("s2_wait_no_capture", 64'(bus.rf_r_ctrl), 64'd0);
            chk("s2_wait_busy", 64'(bus.busy), 64'd1);
            chk("s2_wait_win_valid", 64'(bus.win_valid), 64'd1);
            tick();
        end
        bus.win_ready = 1'b1;
        @(negedge clk);
        chk("s2_ready_cycle_no_capture", 64'(bus.rf_r_ctrl), 64'd0);
        tick();
        bus.win_ready = 1'b0;
        @(negedge clk);
        chk("s2_capture_strobe", 64'(bus.rf_r_ctrl), 64'd1);
        chk("s2_capture_win_valid", 64'(bus.win_valid), 64'd0);
        tick();
        @(negedge clk);
        chk("s2_win_valid", 64'(bus.win_valid), 64'd1);
        chk("s2_win_count", 64'(bus.win_count), 64'd2);
        tick();
        bus.win_ready = 1'b1;
        tick();
        bus.win_ready = 1'b0;

        // Gapped stream: idle cycles between every beat.
        for (int k = 0; k < NB; k++) begin
            send_pair(DW'(2 * k), DW'(2 * k + 1));
            tick();
        end
        repeat (3) tick();
        bus.win_ready = 1'b1;
        tick();
        bus.win_ready = 1'b0;

        // Flush on beat 6 restarts the window at address 0.
        for (int k = 0; k < 6; k++) send_pair(DW'(300 + k), DW'(400 + k));
        bus.flush = 1'b1;
        bus.px_valid = 1'b1;
        bus.px_data1 = 16'hAAAA;
        bus.px_data2 = 16'hBBBB;
        @(negedge clk);
        chk("flush_px_ready", 64'(bus.px_ready), 64'd0);
        chk("flush_busy_before", 64'(bus.busy), 64'd1);
        tick();
        bus.flush = 1'b0;
        bus.px_valid = 1'b0;
        k_model = 0;
        @(negedge clk);
        chk("flush_busy_after", 64'(bus.busy), 64'd0);
        tick();
        for (int k = 0; k < NB; k++) send_pair(DW'(500 + k), DW'(600 + k));
        repeat (3) tick();
        bus.win_ready = 1'b1;
        tick();
        bus.win_ready = 1'b0;

        // Reset mid-window, then a full window from address 0.
        for (int k = 0; k < 8; k++) send_pair(DW'($urandom), DW'($urandom));
        rst = 1'b1;
        bus.px_valid = 1'b1;
        @(negedge clk);
        chk("midrst_px_ready", 64'(bus.px_ready), 64'd0);
        tick();
        rst = 1'b0;
        bus.px_valid = 1'b0;
        k_model = 0;
        cnt_model = 0;
        @(negedge clk);
        chk("midrst_win_valid", 64'(bus.win_valid), 64'd0);
        chk("midrst_win_count", 64'(bus.win_count), 64'd0);
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        tick();
        for (int k = 0; k < NB; k++) send_pair(DW'($urandom), DW'($urandom));
        tick();
        @(negedge clk);
        chk("midrst_count_after_window", 64'(bus.win_count), 64'd1);
        tick();

        // Randomized stream with random gaps and random downstream readiness.
        drv_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 5 * NB; k++) begin
                    send_pair(DW'($urandom), DW'($urandom));
                    repeat ($urandom_range(0, 2)) tick();
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    bus.win_ready = 1'($urandom_range(0, 1));
                    tick();
                end
            end
        join
        bus.win_ready = 1'b1;
        for (int i = 0; i < 100 && (wq.size() + cq.size()) != 0; i++) tick();
        repeat (2) tick();
        chk("queues_drained", 64'(wq.size() + cq.size()), 64'd0);
        bus.win_ready = 1'b0;

        // reg_num=4 instance: two beats per window, no duplicated address.
        bus2.px_valid = 1'b1;
        for (int j = 0; j < 6; j++) begin
            bus2.px_data1 = DW'(100 + 2 * j);
            bus2.px_data2 = DW'(101 + 2 * j);
            @(negedge clk);
            chk("rn4_wr_ctrl", 64'(bus2.rf_wr_ctrl), 64'(exp_wr[j]));
            chk("rn4_r_ctrl", 64'(bus2.rf_r_ctrl), 64'(exp_r[j]));
            chk("rn4_adrs1", 64'(bus2.rf_adrs_in1), 64'(exp_a1[j]));
            chk("rn4_adrs2", 64'(bus2.rf_adrs_in2), 64'(exp_a2[j]));
            chk("rn4_in2", 64'(bus2.rf_in2), exp_wr[j] != 0 ? 64'(101 + 2 * j) : 64'd0);
            chk("rn4_excl", 64'(bus2.rf_wr_ctrl && bus2.rf_r_ctrl), 64'd0);
            tick();
        end
        bus2.px_valid = 1'b0;
        @(negedge clk);
        chk("rn4_win_count", 64'(bus2.win_count), 64'd2);
        chk("rn4_win_valid", 64'(bus2.win_valid), 64'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/img2col_rf_ctrl.md
# img2col_rf_ctrl

Write/read sequencer for the img2col two-write-port register file. It accepts a stream of pixel pairs over a valid/ready handshake and drives the register file write ports with consecutive addresses. Once all `reg_num` entries of a window are loaded, it issues a one-cycle bulk-read strobe and presents the captured window to the downstream MAC array with a valid/ready handshake. Loading of the next window overlaps with the downstream hold of the current one.

## Interface
Parameters:
- `data_width`, 16, pixel width.
- `reg_num`, 25, window size (entries per window); legal range 2 ≤ reg_num ≤ 2^address_num.
- `address_num`, 5, register file address width.
- `cnt_width`, 16, width of the window counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `flush`  in  1  synchronous abort of the partially loaded window.
- `px_valid`  in  1  pixel pair valid.
- `px_ready`  out  1  pixel pair accepted when `px_valid && px_ready`.
- `px_data1`, `px_data2`  in  data_width  pixel pair; `px_data1` goes to the lower address.
- `rf_wr_ctrl`  out  1  register file write strobe.
- `rf_r_ctrl`  out  1  register file bulk-read strobe.
- `rf_in1`, `rf_in2`  out  data_width  register file write data.
- `rf_adrs_in1`, `rf_adrs_in2`  out  address_num  register file write addresses.
- `win_valid`  out  1  register file `out` holds a complete window.
- `win_ready`  in  1  downstream has consumed the window.
- `win_count`  out  cnt_width  number of windows handed off (wraps).
- `busy`  out  1  the state is not FILL or the beat counter is not zero.

## Operation
- Beats per window: `NB = ceil(reg_num/2)`. `beat` counter runs 0..NB-1.
- FSM states: FILL, WAIT, CAPTURE.
- **FILL**
  - `px_ready = !flush`.
  - On an accepted beat:
    - `rf_wr_ctrl = 1`.
    - `rf_adrs_in1 = 2*beat`, `rf_in1 = px_data1`.
    - `rf_adrs_in2 = 2*beat+1`, `rf_in2 = px_data2`.
  - If `reg_num` is odd and `beat == NB-1`: `rf_adrs_in2 = rf_adrs_in1` and `rf_in2 = px_data1`. `px_data2` is discarded, so no out-of-range address is ever issued.
  - Accepted beat with `beat < NB-1`: beat+1.
  - Accepted beat with `beat == NB-1`: beat cleared to 0. Next state is CAPTURE if the slot is free (`!win_valid || win_ready`), otherwise WAIT.
- **WAIT**
  - `px_ready = 0`, no writes.
  - Go to CAPTURE in the cycle after `!win_valid || win_ready` holds.
- **CAPTURE**
  - `rf_r_ctrl = 1` for exactly one cycle.
  - `rf_wr_ctrl = 0`, `px_ready = 0`.
  - At the end of the cycle: `win_valid <= 1`, `win_count <= win_count + 1` (modulo 2^cnt_width). Next state is FILL.
- `rf_wr_ctrl` and `rf_r_ctrl` are never high in the same cycle.
- `rf_adrs_*` and `rf_in*` are 0 whenever `rf_wr_ctrl = 0`.
- `win_valid` stays high until a cycle with `win_ready = 1`, then clears at that edge. It is never set and cleared at the same edge, because CAPTURE is only entered when the slot is free.
- **flush**
  - In FILL or WAIT: beat goes to 0, state goes to FILL, and no write occurs that cycle.
  - In CAPTURE: ignored (the capture completes).
  - `win_valid` and `win_count` are unaffected.

## Timing
- All `rf_*` outputs and `px_ready` are combinational from the state, `beat`, `flush` and the pixel inputs. `win_valid`, `win_count` and `busy` are registered.
- Register file latency: a write lands at the edge ending the write cycle; `out` updates at the edge ending CAPTURE. `win_valid` therefore rises in the same cycle that `out` becomes valid.
- Back-to-back best case with reg_num=25:
  - 13 beats on cycles 0–12.
  - CAPTURE on cycle 13.
  - `win_valid` high from cycle 14.
  - Next window beats start on cycle 14.
- Throughput: NB+1 cycles per window with a free slot.
- Reset (`rst` high at an edge):
  - State FILL, beat 0.
  - `win_valid = 0`, `win_count = 0`, `busy = 0`.
  - While `rst` is high: `px_ready = 0` and all `rf_*` outputs are 0.
  - Reset mid-window discards the partial window. The register file contents are not cleared by this block.

## Test plan
- Reset then 13 continuous beats with pairs (2k, 2k+1) → addresses 0/1 … 22/23, then 24/24 with `rf_in2 = 24`. `rf_r_ctrl` high on cycle 13 only. `win_valid` rises on cycle 14. `win_count = 1`.
- `win_ready` held 0, stream two windows → window 2 loads during cycles 14–26. FSM sits in WAIT with `px_ready = 0`. On `win_ready = 1` at cycle 30: `win_valid` drops at cycle 31 (CAPTURE), rises at cycle 32. `win_count = 2`.
- Gapped `px_valid` (every other cycle) → beat advances only on handshakes; no write on idle cycles; same addresses as the first scenario.
- `flush` asserted on beat 6 → no write that cycle. The next accepted beat writes addresses 0/1, and a full 13 beats are needed before CAPTURE.
- `rst` pulse during beat 8, then a full window → clean restart at address 0. `win_count = 1` after the window.
- Parameter override reg_num=4, address_num=2 → 2 beats at addresses 0/1 and 2/3, with no duplicated address. Checker asserts `rf_wr_ctrl && rf_r_ctrl` never occurs.
